// File: rtl/fetch_pkg.sv
// Shared CPU definitions for the fetch stage: FSM encoding, NOP and the
// default reset PC.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2,
        ST_KILL = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buf.sv
// One-entry skid buffer holding an instruction word and its word address
// while decode is stalled.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic        clear_i,
    input  logic [31:0] data_i,
    input  logic [31:0] addr_i,
    output logic [31:0] data_o,
    output logic [31:0] addr_o,
    output logic        valid_o
);

    logic [31:0] data_q, data_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;

    // Clear wins over load so a squashed word can never be captured.
    always_comb begin
        data_d  = data_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            data_d  = data_i;
            addr_d  = addr_i;
            valid_d = 1'b1;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= NOP;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign addr_o  = addr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: issues word reads, delivers ir/pc to decode,
// absorbs decode stalls with a skid buffer and handles redirects.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        pc_we,
    input  logic [31:0] pc_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        ir_valid
);

    fetch_state_e state_q, state_d;
    // addr_q is the request address (the fetch PC outside KILL);
    // tgt_q holds the redirect target while the stale request drains.
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  tgt_q, tgt_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic         irv_q, irv_d;

    logic         redirect;
    logic         buf_load, buf_unload, buf_clear;
    logic [31:0]  buf_data, buf_addr;
    logic         buf_valid;

    assign redirect = pc_we && irv_q && !stall;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tgt_d      = tgt_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        irv_d      = irv_q;
        buf_load   = 1'b0;
        buf_unload = 1'b0;
        buf_clear  = 1'b0;
        imem_req   = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_BUSY;
            ST_BUSY: begin
                imem_req = 1'b1;
                if (redirect) begin
                    irv_d     = 1'b0;
                    buf_clear = 1'b1;
                    if (imem_ack) begin
                        addr_d = pc_data;
                    end else begin
                        tgt_d   = pc_data;
                        state_d = ST_KILL;
                    end
                end else if (stall) begin
                    if (imem_ack) begin
                        buf_load = 1'b1;
                        addr_d   = addr_q + 32'd1;
                        state_d  = ST_HOLD;
                    end
                end else if (imem_ack) begin
                    ir_d   = imem_rdata;
                    pc_d   = addr_q + 32'd1;
                    irv_d  = 1'b1;
                    addr_d = addr_q + 32'd1;
                end else begin
                    irv_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    irv_d     = 1'b0;
                    buf_clear = 1'b1;
                    addr_d    = pc_data;
                    state_d   = ST_BUSY;
                end else if (!stall && buf_valid) begin
                    ir_d       = buf_data;
                    pc_d       = buf_addr + 32'd1;
                    irv_d      = 1'b1;
                    buf_unload = 1'b1;
                    state_d    = ST_BUSY;
                end
            end
            ST_KILL: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    addr_d  = tgt_q;
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= RESET_PC;
            tgt_q   <= RESET_PC;
            pc_q    <= '0;
            ir_q    <= NOP;
            irv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            irv_q   <= irv_d;
        end
    end

    fetch_buf u_buf (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_i   (buf_load),
        .unload_i (buf_unload),
        .clear_i  (buf_clear),
        .data_i   (imem_rdata),
        .addr_i   (addr_q),
        .data_o   (buf_data),
        .addr_o   (buf_addr),
        .valid_o  (buf_valid)
    );

    assign imem_addr = addr_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign ir_valid  = irv_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for the fetch stage: directed scenarios plus a randomized run checked
// against an instruction-stream model (program order + redirects).
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        pc_we = 1'b0;
    logic [31:0] pc_data = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        ir_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .pc_we      (pc_we),
        .pc_data    (pc_data),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .ir         (ir),
        .ir_valid   (ir_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        stall    = 1'b0;
        pc_we    = 1'b0;
        pc_data  = '0;
        imem_ack = 1'b0;
        @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_irv", {31'b0, ir_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("idle_req", {31'b0, imem_req}, 32'd0);
    endtask

    task automatic run_until_addr(input logic [31:0] target);
        for (int i = 0; i < 20 && imem_addr !== target; i++) @(negedge clk);
        chk("reach_addr", imem_addr, target);
    endtask

    logic [31:0] exp_next;
    logic [31:0] prev_addr;
    logic        prev_wait;
    int          consumed;

    initial begin
        // Zero-wait memory: one instruction per cycle after the IDLE cycle.
        do_reset();
        imem_ack = 1'b1;
        @(negedge clk);
        chk("a_req", {31'b0, imem_req}, 32'd1);
        chk("a_addr", imem_addr, 32'd0);
        chk("a_irv0", {31'b0, ir_valid}, 32'd0);
        @(negedge clk);
        chk("a_irv1", {31'b0, ir_valid}, 32'd1);
        chk("a_pc1", pc, 32'd1);
        chk("a_ir1", ir, mem_word(32'd0));
        @(negedge clk);
        chk("a_pc2", pc, 32'd2);
        @(negedge clk);
        chk("a_pc3", pc, 32'd3);
        chk("a_ir3", ir, mem_word(32'd2));

        // Ack delayed three cycles: address held, three bubbles.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b_addr", imem_addr, 32'd0);
            chk("b_req", {31'b0, imem_req}, 32'd1);
            chk("b_bubble", {31'b0, ir_valid}, 32'd0);
        end
        imem_ack = 1'b1;
        @(negedge clk);
        chk("b_irv", {31'b0, ir_valid}, 32'd1);
        chk("b_pc", pc, 32'd1);
        chk("b_ir", ir, mem_word(32'd0));

        // Two-cycle stall coincident with the ack of address 5.
        do_reset();
        imem_ack = 1'b1;
        run_until_addr(32'd5);
        stall = 1'b1;
        @(negedge clk);
        chk("c_pc_hold", pc, 32'd5);
        chk("c_ir_hold", ir, mem_word(32'd4));
        chk("c_hold_req", {31'b0, imem_req}, 32'd0);
        chk("c_irv_hold", {31'b0, ir_valid}, 32'd1);
        @(negedge clk);
        chk("c_pc_hold2", pc, 32'd5);
        stall = 1'b0;
        @(negedge clk);
        chk("c_pc6", pc, 32'd6);
        chk("c_ir5", ir, mem_word(32'd5));
        chk("c_addr6", imem_addr, 32'd6);
        chk("c_req", {31'b0, imem_req}, 32'd1);
        @(negedge clk);
        chk("c_pc7", pc, 32'd7);

        // Redirect while the request to 7 is outstanding.
        do_reset();
        imem_ack = 1'b1;
        run_until_addr(32'd7);
        imem_ack = 1'b0;
        pc_we    = 1'b1;
        pc_data  = 32'h40;
        @(negedge clk);
        pc_we = 1'b0;
        chk("d_kill_addr", imem_addr, 32'd7);
        chk("d_kill_req", {31'b0, imem_req}, 32'd1);
        chk("d_kill_irv", {31'b0, ir_valid}, 32'd0);
        @(negedge clk);
        chk("d_kill_addr2", imem_addr, 32'd7);
        imem_ack = 1'b1;
        @(negedge clk);
        chk("d_new_addr", imem_addr, 32'h40);
        chk("d_no_w7", {31'b0, ir_valid}, 32'd0);
        @(negedge clk);
        chk("d_pc41", pc, 32'h41);
        chk("d_ir40", ir, mem_word(32'h40));

        // Redirect request during a stall is ignored.
        do_reset();
        imem_ack = 1'b1;
        run_until_addr(32'd3);
        stall   = 1'b1;
        pc_we   = 1'b1;
        pc_data = 32'h80;
        @(negedge clk);
        chk("e_pc_hold", pc, 32'd3);
        stall = 1'b0;
        pc_we = 1'b0;
        @(negedge clk);
        chk("e_pc4", pc, 32'd4);
        chk("e_ir3", ir, mem_word(32'd3));
        chk("e_addr4", imem_addr, 32'd4);
        @(negedge clk);
        chk("e_pc5", pc, 32'd5);

        // PC wrap at the top of the address space.
        pc_we   = 1'b1;
        pc_data = 32'hFFFF_FFFF;
        @(negedge clk);
        pc_we = 1'b0;
        chk("g_addr_top", imem_addr, 32'hFFFF_FFFF);
        chk("g_irv0", {31'b0, ir_valid}, 32'd0);
        @(negedge clk);
        chk("g_pc_wrap", pc, 32'd0);
        chk("g_ir_top", ir, mem_word(32'hFFFF_FFFF));
        chk("g_addr_wrap", imem_addr, 32'd0);

        // Asynchronous reset while in KILL.
        do_reset();
        imem_ack = 1'b1;
        run_until_addr(32'd7);
        imem_ack = 1'b0;
        pc_we    = 1'b1;
        pc_data  = 32'h40;
        @(negedge clk);
        pc_we = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("f_req", {31'b0, imem_req}, 32'd0);
        chk("f_addr", imem_addr, 32'd0);
        chk("f_pc", pc, 32'd0);
        chk("f_ir", ir, 32'd0);
        chk("f_irv", {31'b0, ir_valid}, 32'd0);
        imem_ack = 1'b1;
        @(negedge clk);
        chk("f_ack_ignored", {31'b0, ir_valid}, 32'd0);
        rst = 1'b0;
        chk("f_idle_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        chk("f_restart", imem_addr, 32'd0);
        @(negedge clk);
        chk("f_pc1", pc, 32'd1);
        chk("f_ir0", ir, mem_word(32'd0));

        // Randomized run: every accepted instruction must follow program
        // order from the last accepted one, or jump to an honoured target.
        do_reset();
        exp_next  = 32'd0;
        prev_wait = 1'b0;
        prev_addr = '0;
        consumed  = 0;
        for (int c = 0; c < 800; c++) begin
            if (prev_wait && imem_req) chk("r_addr_stable", imem_addr, prev_addr);
            stall    = ($urandom_range(0, 3) == 0);
            imem_ack = imem_req && ($urandom_range(0, 1) == 1);
            pc_we    = ($urandom_range(0, 4) == 0);
            pc_data  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : ($urandom & 32'h0000_00FF);
            if (ir_valid && !stall) begin
                chk("r_seq_pc", pc - 32'd1, exp_next);
                chk("r_seq_ir", ir, mem_word(pc - 32'd1));
                exp_next = pc_we ? pc_data : pc;
                consumed++;
            end
            prev_wait = imem_req && !imem_ack;
            prev_addr = imem_addr;
            @(negedge clk);
        end
        chk("r_progress", {31'b0, consumed >= 100}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, word address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 stall  input  1  decode stage cannot accept a new instruction; ID outputs hold.
REQ-005 pc_we  input  1  redirect request from decode (taken branch/jump).
REQ-006 pc_data  input  32  redirect target, word address.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  word address of the outstanding request.
REQ-009 imem_ack  input  1  read data valid this cycle; may be asserted in the same cycle as imem_req.
REQ-010 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-011 pc  output  32  fetched-instruction word address + 1, to decode (branch base).
REQ-012 ir  output  32  instruction register, to decode.
REQ-013 ir_valid  output  1  ir/pc hold a live instruction; 0 = bubble.

Function
REQ-014 States SHALL be IDLE, BUSY, HOLD, KILL, held in a state register.
REQ-015 IDLE: imem_req=0; next state BUSY unconditionally.
REQ-016 BUSY: imem_req=1, imem_addr=fetch PC; imem_req and imem_addr stable until imem_ack.
REQ-017 BUSY, imem_ack=1, stall=0, no redirect: ir<=imem_rdata, pc<=imem_addr+1, ir_valid<=1, fetch PC<=imem_addr+1, stay BUSY (throughput one instruction per cycle with zero-wait memory).
REQ-018 BUSY, imem_ack=0, stall=0: ir_valid<=0 (bubble); ir, pc unchanged.
REQ-019 BUSY, imem_ack=1, stall=1: word and its address captured into one-entry skid buffer; fetch PC advances; next state HOLD.
REQ-020 HOLD: imem_req=0; when stall=0, buffer moves to ir/pc, ir_valid<=1, next state BUSY.
REQ-021 Whenever stall=1, ir, pc, ir_valid SHALL hold their values.
REQ-022 Redirect SHALL be honoured only when pc_we=1, ir_valid=1 and stall=0; otherwise pc_we is ignored.
REQ-023 Redirect: fetch PC<=pc_data; ir_valid<=0 (no delay slot; in-flight and buffered words squashed); skid buffer cleared.
REQ-024 Redirect in BUSY with imem_ack=0: next state KILL; imem_req stays 1 at the old imem_addr.
REQ-025 KILL: on imem_ack the returned word SHALL be discarded and next state BUSY at the new fetch PC; ir_valid remains 0.
REQ-026 Redirect in BUSY with imem_ack=1, or in HOLD: returned/buffered word discarded, next state BUSY at pc_data.
REQ-027 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFF + 1 wraps to 0.

Reset
REQ-028 On rst: state=IDLE, fetch PC=RESET_PC, imem_addr=RESET_PC, imem_req=0, pc=0, ir=32'h0000_0000 (NOP), ir_valid=0, skid buffer empty.
REQ-029 Reset mid-request SHALL abandon the outstanding request; any imem_ack during reset is ignored.

Structure
REQ-030 State encodings, NOP constant and default RESET_PC SHALL live in the shared CPU definitions package/header.
REQ-031 The skid buffer SHALL be a sub-module fetch_buf (data 32, address 32, valid, load/unload/clear).

Verification
REQ-032 Reset release, RESET_PC=0, imem_ack tied 1 -> imem_req first in cycle 2; ir_valid=1 with pc=1,2,3 on consecutive cycles.
REQ-033 imem_ack delayed 3 cycles -> imem_addr stable, 3 bubbles (ir_valid=0), then one valid instruction.
REQ-034 stall=1 for 2 cycles coincident with ack of addr 5 -> ir/pc frozen, HOLD entered, ir=word@5, pc=6 on first cycle after stall drops.
REQ-035 pc_we=1, pc_data=0x40 while request to addr 7 outstanding -> KILL, word@7 never appears on ir, next imem_addr=0x40.
REQ-036 pc_we=1 with stall=1 -> no redirect, fetch sequence unchanged.
REQ-037 rst asserted mid-KILL -> all outputs at REQ-028 values asynchronously, fetch restarts at RESET_PC.
